// File: rtl/data_mem_pkg.sv
// Shared types and sizing helpers for the MEM-stage data memory controller.
package data_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned BYTE_W     = 32'd8;
  localparam int unsigned DEF_DATA_W = 32'd16;
  localparam int unsigned DEF_LANES  = DEF_DATA_W / BYTE_W;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // Index width for n entries, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    int unsigned v;
    w = 32'd0;
    v = n - 32'd1;
    while (v > 32'd0) begin
      w = w + 32'd1;
      v = v >> 1;
    end
    if (w == 32'd0) begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with per-byte write enables and a registered read port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd16,
  parameter int unsigned DEPTH  = 32'd256,
  localparam int unsigned IDX_W = clog2_min1(DEPTH),
  localparam int unsigned LANES = lane_count(DATA_W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LANES-1:0]  wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Lane-masked write and synchronous read of the addressed word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (wr_be[i]) begin
          mem_r[idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data_r <= mem_r[idx];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/data_memory_ctrl.sv
// Valid/ready front end for the data store: clear sequencer, range check and
// one-cycle registered response.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32'd16,
  parameter int unsigned ADDR_W         = 32'd16,
  parameter int unsigned DEPTH          = 32'd256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [(DATA_W/8)-1:0]    req_be,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_err,
  output logic                     init_done
);

  localparam int unsigned    IDX_W    = clog2_min1(DEPTH);
  localparam int unsigned    LANES    = lane_count(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 32'd1);
  localparam state_e         RST_ST   = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e             state_r;
  state_e             state_next_s;
  logic [IDX_W-1:0]   clr_ptr_r;
  logic               ready_s;
  logic               clear_en_s;
  logic               accept_s;
  logic               in_range_s;

  logic               arr_we_s;
  logic               arr_re_s;
  logic [LANES-1:0]   arr_be_s;
  logic [IDX_W-1:0]   arr_idx_s;
  logic [DATA_W-1:0]  arr_wdata_s;
  logic [DATA_W-1:0]  arr_rdata_s;

  logic               resp_valid_r;
  logic               resp_err_r;
  logic               rd_sel_r;
  logic               init_done_r;

  assign accept_s   = req_valid & ready_s;
  assign in_range_s = ({1'b0, req_addr} < DEPTH_L);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RST_ST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: clear walks every word once, then run forever.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_ptr_r == LAST_IDX) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = RST_ST;
    endcase
  end

  // State decode; ready depends on state alone.
  always_comb begin
    ready_s    = 1'b0;
    clear_en_s = 1'b0;
    case (state_r)
      ST_CLEAR: clear_en_s = 1'b1;
      ST_RUN:   ready_s    = 1'b1;
      default: begin
        ready_s    = 1'b0;
        clear_en_s = 1'b0;
      end
    endcase
  end

  // Array port mux: clear write has priority; nothing lands on a reset edge.
  always_comb begin
    arr_we_s    = 1'b0;
    arr_re_s    = 1'b0;
    arr_be_s    = '0;
    arr_idx_s   = '0;
    arr_wdata_s = '0;
    if (clear_en_s) begin
      arr_we_s    = ~rst;
      arr_be_s    = '1;
      arr_idx_s   = clr_ptr_r;
      arr_wdata_s = '0;
    end else begin
      arr_we_s    = accept_s & req_we & in_range_s & ~rst;
      arr_re_s    = accept_s & ~req_we & in_range_s;
      arr_be_s    = req_be;
      arr_idx_s   = req_addr[IDX_W-1:0];
      arr_wdata_s = req_wdata;
    end
  end

  // Clear pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr_r <= '0;
    end else if (clear_en_s) begin
      clr_ptr_r <= clr_ptr_r + IDX_W'(1);
    end else begin
      clr_ptr_r <= clr_ptr_r;
    end
  end

  // Response registers; error and data select hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      rd_sel_r     <= 1'b0;
      init_done_r  <= 1'b0;
    end else begin
      resp_valid_r <= accept_s;
      if (accept_s) begin
        resp_err_r <= ~in_range_s;
        rd_sel_r   <= ~req_we & in_range_s;
      end
      init_done_r <= (state_next_s == ST_RUN);
    end
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (arr_we_s),
    .wr_be   (arr_be_s),
    .wr_data (arr_wdata_s),
    .rd_en   (arr_re_s),
    .idx     (arr_idx_s),
    .rd_data (arr_rdata_s)
  );

  // The array's read register only updates on in-range reads, so it already
  // holds; writes and errors select zero.
  assign resp_rdata = rd_sel_r ? arr_rdata_s : '0;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign req_ready  = ready_s;
  assign init_done  = init_done_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: a clearing and a non-clearing instance share stimulus and
// are checked against an array-level reference model.
module tb_data_memory_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 8;

  typedef struct {
    logic [15:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic [1:0]  req_be = 2'b00;

  logic        c_ready, c_rvalid, c_err, c_done;
  logic [15:0] c_rdata;
  logic        n_ready, n_rvalid, n_err, n_done;
  logic [15:0] n_rdata;

  logic [15:0] mem_c [DEPTH];
  logic [15:0] mem_n [DEPTH];
  bit   [1:0]  known_n [DEPTH];
  exp_t        q_c[$];
  exp_t        q_n[$];
  int          pushed = 0;
  int          popped_c = 0;
  int          popped_n = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(c_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(c_rvalid),
    .resp_rdata(c_rdata), .resp_err(c_err), .init_done(c_done));

  data_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(n_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(n_rvalid),
    .resp_rdata(n_rdata), .resp_err(n_err), .init_done(n_done));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request, accepted at the next rising edge; expectation pushed after it.
  task automatic issue(input bit we, input int addr, input logic [15:0] wd, input logic [1:0] be);
    exp_t ec, en;
    bit   inr;
    @(negedge clk);
    check("ready_before_issue", {31'd0, c_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = 16'(addr); req_wdata = wd; req_be = be;
    @(posedge clk);
    inr = (addr < DEPTH);
    ec.err = !inr; en.err = !inr;
    ec.data = 16'h0000; en.data = 16'h0000;
    ec.chk_data = 1'b1; en.chk_data = 1'b1;
    if (inr && we) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) begin
          mem_c[addr][i*8 +: 8] = wd[i*8 +: 8];
          mem_n[addr][i*8 +: 8] = wd[i*8 +: 8];
          known_n[addr][i] = 1'b1;
        end
      end
    end else if (inr) begin
      ec.data = mem_c[addr];
      en.data = mem_n[addr];
      en.chk_data = (known_n[addr] == 2'b11);
    end
    q_c.push_back(ec);
    q_n.push_back(en);
    pushed++;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 16'($urandom);
    req_addr = 16'($urandom);
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!c_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check(name, {31'd0, c_done}, 32'd1);
  endtask

  // Monitor: every response pulse pops and compares one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (c_rvalid) begin
      if (q_c.size() == 0) begin
        check("c_unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = q_c.pop_front();
        popped_c++;
        check("c_resp_err", {31'd0, c_err}, {31'd0, e.err});
        check("c_resp_rdata", {16'd0, c_rdata}, {16'd0, e.data});
      end
    end
    if (n_rvalid) begin
      if (q_n.size() == 0) begin
        check("n_unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = q_n.pop_front();
        popped_n++;
        check("n_resp_err", {31'd0, n_err}, {31'd0, e.err});
        if (e.chk_data) begin
          check("n_resp_rdata", {16'd0, n_rdata}, {16'd0, e.data});
        end
      end
    end
  end

  initial begin
    int  cyc;
    bit  saw_ready;
    int  sel, addr;
    for (int i = 0; i < DEPTH; i++) begin
      mem_c[i] = 16'h0000; mem_n[i] = 16'h0000; known_n[i] = 2'b00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c_ready", {31'd0, c_ready}, 32'd0);
    check("rst_c_done", {31'd0, c_done}, 32'd0);
    check("rst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
    check("rst_c_err", {31'd0, c_err}, 32'd0);
    check("rst_c_rdata", {16'd0, c_rdata}, 32'd0);
    check("rst_n_ready", {31'd0, n_ready}, 32'd1);
    check("rst_n_done", {31'd0, n_done}, 32'd0);
    rst = 1'b0;

    // Clear sequence length and ready held low throughout.
    cyc = 0; saw_ready = 1'b0;
    while (!c_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("n_done_first_edge", {31'd0, n_done}, 32'd1);
      if (!c_done && c_ready) saw_ready = 1'b1;
    end
    check("clear_cycles", 32'(cyc), 32'd8);
    check("ready_low_in_clear", {31'd0, saw_ready}, 32'd0);
    check("ready_after_clear", {31'd0, c_ready}, 32'd1);

    for (int a = 0; a < DEPTH; a++) issue(1'b0, a, 16'h0000, 2'b00);
    idle();
    issue(1'b1, 5, 16'hBEEF, 2'b11);
    issue(1'b0, 5, 16'h0000, 2'b00);
    issue(1'b1, 3, 16'hBEEF, 2'b11);
    issue(1'b1, 3, 16'h12AB, 2'b01);
    issue(1'b0, 3, 16'h0000, 2'b00);
    issue(1'b1, 3, 16'h5555, 2'b00);
    issue(1'b0, 3, 16'h0000, 2'b00);
    issue(1'b1, 8, 16'hFFFF, 2'b11);
    issue(1'b0, 8, 16'h0000, 2'b00);
    issue(1'b0, 16'h0010, 16'h0000, 2'b00);
    issue(1'b0, 0, 16'h0000, 2'b00);
    issue(1'b0, 16'hFFFF, 16'h0000, 2'b00);
    idle();
    for (int a = 0; a < DEPTH; a++) issue(1'b0, a, 16'h0000, 2'b00);
    idle();

    for (int k = 0; k < 300; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) addr = int'($urandom_range(0, DEPTH - 1));
      else if (sel < 9) addr = int'($urandom_range(DEPTH, 2 * DEPTH - 1));
      else addr = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) idle();
      else issue(1'($urandom), addr, 16'($urandom), 2'($urandom));
    end

    // Reset landing on a read accept: no response, clear re-runs.
    issue(1'b1, 5, 16'hBEEF, 2'b11);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd5; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
    check("midrst_n_rvalid", {31'd0, n_rvalid}, 32'd0);
    check("midrst_c_ready", {31'd0, c_ready}, 32'd0);
    check("midrst_c_done", {31'd0, c_done}, 32'd0);
    rst = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_c[i] = 16'h0000;
    wait_done("reclear_done");
    issue(1'b0, 5, 16'h0000, 2'b00);
    issue(1'b0, 0, 16'h0000, 2'b00);
    repeat (3) idle();

    check("c_queue_empty", 32'(q_c.size()), 32'd0);
    check("n_queue_empty", 32'(q_n.size()), 32'd0);
    check("c_pulse_count", 32'(popped_c), 32'(pushed));
    check("n_pulse_count", 32'(popped_n), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
